// File: rtl/keypad_scan_debounce.sv
`default_nettype none
// ============================================================================
// keypad_scan_debounce : 4x4 matrix keypad scanner with press/release debounce,
// hex encoding and auto-addressed register-bank write generation.
// Revision: 1.0
// ============================================================================
module keypad_scan_debounce #(
  parameter logic [15:0] SCAN_DIV  = 16'd50_000,
  parameter logic [19:0] DB_CYCLES = 20'd500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols_n,
  input  logic       wr_addr_clr,
  output logic [3:0] rows_n,
  output logic [1:0] row_sel,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       wr_en,
  output logic [1:0] wr_addr,
  output logic [7:0] wr_data
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [15:0] DWELL_LAST = SCAN_DIV - 16'd1;
  localparam logic [19:0] DB_LAST    = DB_CYCLES - 20'd1;

  state_t      state, state_nx;
  logic [3:0]  sync1, sync2, cols;
  logic [3:0]  cap_cols, cap_nx;
  logic [15:0] dwell_cnt, dwell_nx;
  logic [19:0] db_cnt, db_nx;
  logic [1:0]  row_nx;
  logic [1:0]  low_col;
  logic        accept;

  assign cols     = ~sync2;
  assign rows_n   = ~(4'b0001 << row_sel);
  assign key_held = (state == PRESSED) || (state == RELEASE);
  assign wr_en    = key_valid;
  assign wr_data  = {4'b0000, key_code};

  // Lowest-index active column wins when several keys share the row.
  always_comb begin
    low_col = 2'd0;
    if (cap_cols[0])      low_col = 2'd0;
    else if (cap_cols[1]) low_col = 2'd1;
    else if (cap_cols[2]) low_col = 2'd2;
    else if (cap_cols[3]) low_col = 2'd3;
  end

  always_comb begin
    state_nx = state;
    row_nx   = row_sel;
    dwell_nx = dwell_cnt;
    db_nx    = db_cnt;
    cap_nx   = cap_cols;
    accept   = 1'b0;
    case (state)
      SCAN: begin
        if (dwell_cnt == DWELL_LAST) begin
          if (cols != 4'd0) begin
            state_nx = DEBOUNCE;
            cap_nx   = cols;
            db_nx    = 20'd0;
          end else begin
            row_nx   = row_sel + 2'd1;
            dwell_nx = 16'd0;
          end
        end else begin
          dwell_nx = dwell_cnt + 16'd1;
        end
      end
      DEBOUNCE: begin
        if (cols != cap_cols) begin
          state_nx = SCAN;
          row_nx   = row_sel + 2'd1;
          dwell_nx = 16'd0;
        end else if (db_cnt == DB_LAST) begin
          accept   = 1'b1;
          state_nx = PRESSED;
        end else begin
          db_nx = db_cnt + 20'd1;
        end
      end
      PRESSED: begin
        if (cols == 4'd0) begin
          state_nx = RELEASE;
          db_nx    = 20'd0;
        end
      end
      RELEASE: begin
        // Any activity here is release bounce: resume PRESSED without a new pulse.
        if (cols != 4'd0) begin
          state_nx = PRESSED;
        end else if (db_cnt == DB_LAST) begin
          state_nx = SCAN;
          row_nx   = row_sel + 2'd1;
          dwell_nx = 16'd0;
        end else begin
          db_nx = db_cnt + 20'd1;
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 4'b1111;
      sync2     <= 4'b1111;
      state     <= SCAN;
      row_sel   <= 2'd0;
      dwell_cnt <= 16'd0;
      db_cnt    <= 20'd0;
      cap_cols  <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      wr_addr   <= 2'd0;
    end else begin
      sync1     <= cols_n;
      sync2     <= sync1;
      state     <= state_nx;
      row_sel   <= row_nx;
      dwell_cnt <= dwell_nx;
      db_cnt    <= db_nx;
      cap_cols  <= cap_nx;
      key_valid <= accept;
      if (accept) key_code <= {row_sel, low_col};
      // Clear wins over increment; a coincident write still used the old address.
      if (wr_addr_clr)  wr_addr <= 2'd0;
      else if (wr_en)   wr_addr <= wr_addr + 2'd1;
    end
  end

endmodule
`default_nettype wire
